gold_cdma_engine: RTL and testbench

Parametrised Gold-code CDMA spreader/despreader. Two N-bit Fibonacci LFSRs generate a Gold sequence. A valid/ready input spreads each data bit over SF chips. An optional on-chip correlator despreads a received chip stream into recovered bits. Sits between the user data source and the chip-level pad I/O, replacing the fixed 5-bit, one-chip-per-bit spreader.

---
 rtl/gold_cdma_engine.sv | 188 ++++++++++++++++++
 tb/tb_gold_cdma_engine.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gold_cdma_engine.sv
// ---------------------------------------------------------------------------
// gold_cdma_engine
//
// Gold-code CDMA spreader with an optional on-chip despreading correlator.
// Two N-bit Fibonacci LFSRs (feedback masks TAPS_A / TAPS_B) run in lockstep,
// and the XOR of their MSBs is the Gold chip. Each accepted data bit is spread
// over SF chips. The correlator (when built in) counts despread ones over one
// symbol and decides the received bit by majority.
//
// Build option:
//   GOLD_CDMA_CORRELATOR_EN  - defined: correlator present (rx_bit_o/rx_valid_o
//                              live). Undefined: rx outputs tied to 0.
//
// Ports:
//   clk_i          chip clock, rising edge
//   set_i          asynchronous active-low reset
//   seed_i[N]      seed for both LFSRs (zero is replaced by 1)
//   load_i         synchronous reseed / abort, highest priority
//   en_i           chip-step enable
//   data_valid_i   tx bit valid
//   data_i         tx bit
//   data_ready_o   tx bit accepted this cycle when data_valid_i is high
//   cdma_o         spread chip (registered)
//   gold_o         Gold chip used for cdma_o (registered)
//   chip_valid_o   cdma_o/gold_o updated this cycle
//   receptor_i     received chip
//   receptor_o     receptor_i ^ current Gold chip (combinational)
//   rx_bit_o       recovered bit
//   rx_valid_o     one-cycle strobe for rx_bit_o
//   led_o          seed_i nonzero (combinational)
// ---------------------------------------------------------------------------
module gold_cdma_engine #(
    parameter int           N      = 5,
    parameter logic [N-1:0] TAPS_A = 5'b11110,
    parameter logic [N-1:0] TAPS_B = 5'b10010,
    parameter int           SF     = 31
) (
    input  logic         clk_i,
    input  logic         set_i,
    input  logic [N-1:0] seed_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic         data_valid_i,
    input  logic         data_i,
    output logic         data_ready_o,
    output logic         cdma_o,
    output logic         gold_o,
    output logic         chip_valid_o,
    input  logic         receptor_i,
    output logic         receptor_o,
    output logic         rx_bit_o,
    output logic         rx_valid_o,
    output logic         led_o
);

    localparam int CNT_W = (SF > 1) ? $clog2(SF) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     lfsr_a_q, lfsr_b_q;
    logic [N-1:0]     eff_seed;
    logic [CNT_W-1:0] chip_cnt_q;
    logic             tx_bit_q;
    logic             gold_chip;
    logic             chip_step;
    logic             last_chip;
    logic             accept;

    // An all-zero seed would lock both LFSRs at zero forever.
    assign eff_seed  = (seed_i == '0) ? {{(N-1){1'b0}}, 1'b1} : seed_i;
    assign led_o     = |seed_i;

    assign gold_chip  = lfsr_a_q[N-1] ^ lfsr_b_q[N-1];
    assign receptor_o = receptor_i ^ gold_chip;

    assign chip_step = (state_q == RUN) && en_i && !load_i;
    assign last_chip = chip_step && (chip_cnt_q == CNT_W'(SF - 1));
    assign accept    = data_ready_o && data_valid_i;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; an unassigned path infers a latch.
    always_comb begin
        state_d      = state_q;
        data_ready_o = 1'b0;
        if (load_i) begin
            // Abort: no bit may be accepted in the reseed cycle.
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_ready_o = 1'b1;
                    if (data_valid_i) state_d = RUN;
                end
                RUN: begin
                    // Ready only on the final chip, so a waiting bit follows
                    // back-to-back with no idle chip between symbols.
                    if (last_chip) begin
                        data_ready_o = 1'b1;
                        if (!data_valid_i) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; e.g. cdma_o uses the old tx_bit_q even when
    // the next bit is latched on the same edge.
    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            lfsr_a_q     <= eff_seed;
            lfsr_b_q     <= eff_seed;
            chip_cnt_q   <= '0;
            tx_bit_q     <= 1'b0;
            cdma_o       <= 1'b0;
            gold_o       <= 1'b0;
            chip_valid_o <= 1'b0;
        end else if (load_i) begin
            lfsr_a_q     <= eff_seed;
            lfsr_b_q     <= eff_seed;
            chip_cnt_q   <= '0;
            chip_valid_o <= 1'b0;
        end else begin
            chip_valid_o <= chip_step;
            if (accept) tx_bit_q <= data_i;
            if (chip_step) begin
                cdma_o     <= tx_bit_q ^ gold_chip;
                gold_o     <= gold_chip;
                lfsr_a_q   <= {lfsr_a_q[N-2:0], ^(lfsr_a_q & TAPS_A)};
                lfsr_b_q   <= {lfsr_b_q[N-2:0], ^(lfsr_b_q & TAPS_B)};
                chip_cnt_q <= last_chip ? '0 : chip_cnt_q + CNT_W'(1);
            end
        end
    end

    // --------------------------------------------------------- correlator
`ifdef GOLD_CDMA_CORRELATOR_EN
    localparam int ONES_W = $clog2(SF + 1);

    logic [ONES_W-1:0] ones_cnt_q;
    logic [ONES_W:0]   ones_total;

    // Count including the chip being received now, so the decision on the
    // last chip sees all SF chips of the symbol.
    assign ones_total = {1'b0, ones_cnt_q} + (ONES_W + 1)'(receptor_o);

    always_ff @(posedge clk_i or negedge set_i) begin
        if (!set_i) begin
            ones_cnt_q <= '0;
            rx_bit_o   <= 1'b0;
            rx_valid_o <= 1'b0;
        end else if (load_i) begin
            // A partially received symbol is discarded without a strobe.
            ones_cnt_q <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            rx_valid_o <= last_chip;
            if (chip_step) begin
                if (last_chip) begin
                    rx_bit_o   <= (ones_total > (ONES_W + 1)'(SF / 2));
                    ones_cnt_q <= '0;
                end else begin
                    ones_cnt_q <= ones_total[ONES_W-1:0];
                end
            end
        end
    end
`else
    assign rx_bit_o   = 1'b0;
    assign rx_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_gold_cdma_engine.sv
// ---------------------------------------------------------------------------
// tb_gold_cdma_engine
//
// Self-checking bench for gold_cdma_engine with default parameters. A
// reference model of the two LFSRs, the symbol sequencing and the correlator
// runs alongside the DUT; expected chips and recovered bits are queued when
// stimulus is applied and popped when the DUT presents them. Correlator
// expectations follow GOLD_CDMA_CORRELATOR_EN.
// ---------------------------------------------------------------------------
module tb_gold_cdma_engine;

    localparam int           N      = 5;
    localparam int           SF     = 31;
    localparam logic [N-1:0] TAPS_A = 5'b11110;
    localparam logic [N-1:0] TAPS_B = 5'b10010;

    logic         clk_i = 1'b0;
    logic         set_i = 1'b0;
    logic [N-1:0] seed_i = '0;
    logic         load_i = 1'b0;
    logic         en_i = 1'b0;
    logic         data_valid_i = 1'b0;
    logic         data_i = 1'b0;
    logic         data_ready_o;
    logic         cdma_o;
    logic         gold_o;
    logic         chip_valid_o;
    logic         receptor_i = 1'b0;
    logic         receptor_o;
    logic         rx_bit_o;
    logic         rx_valid_o;
    logic         led_o;

    gold_cdma_engine #(
        .N(N), .TAPS_A(TAPS_A), .TAPS_B(TAPS_B), .SF(SF)
    ) dut (
        .clk_i(clk_i), .set_i(set_i), .seed_i(seed_i), .load_i(load_i),
        .en_i(en_i), .data_valid_i(data_valid_i), .data_i(data_i),
        .data_ready_o(data_ready_o), .cdma_o(cdma_o), .gold_o(gold_o),
        .chip_valid_o(chip_valid_o), .receptor_i(receptor_i),
        .receptor_o(receptor_o), .rx_bit_o(rx_bit_o),
        .rx_valid_o(rx_valid_o), .led_o(led_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    typedef struct packed {
        logic cdma;
        logic gold;
    } chip_t;

    logic [N-1:0] m_a, m_b;
    bit           m_run;
    int           m_cnt;
    logic         m_tx;
    int           m_ones;
    logic         exp_cv, exp_rxv;

    chip_t chip_q[$];
    logic  rx_q[$];
    logic  src_q[$];     // tx bits waiting to be offered on data_i
    logic  gold_hist[$]; // gold_o seen on every chip_valid_o
    int    ready_hist[$];
    logic  ref_gold[SF];

    bit loopback = 1'b0;
    int n_err    = 0;    // chips per symbol to corrupt on the receive side
    int cyc      = 0;
    int cv_count = 0;
    int rx_count = 0;

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s,
                                               input logic [N-1:0] taps);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < N; i++) if (taps[i]) fb = fb ^ s[i];
        return {s[N-2:0], fb};
    endfunction

    function automatic logic [N-1:0] eff_seed(input logic [N-1:0] s);
        return (s == '0) ? N'(1) : s;
    endfunction

    task automatic model_reset();
        m_a    = eff_seed(seed_i);
        m_b    = eff_seed(seed_i);
        m_run  = 1'b0;
        m_cnt  = 0;
        m_ones = 0;
        m_tx   = 1'b0;
        exp_cv = 1'b0;
        exp_rxv = 1'b0;
        chip_q.delete();
        rx_q.delete();
    endtask

    task automatic do_reset(input logic [N-1:0] s);
        @(negedge clk_i);
        set_i  = 1'b0;
        seed_i = s;
        load_i = 1'b0;
        #2;
        model_reset();
        set_i = 1'b1;
    endtask

    // One chip clock: drive inputs, check combinational outputs, advance the
    // model, then check the registered outputs after the rising edge.
    task automatic tick();
        logic  g, exp_ready, r;
        chip_t c;
        g = m_a[N-1] ^ m_b[N-1];
        data_valid_i = (src_q.size() != 0);
        data_i       = (src_q.size() != 0) ? src_q[0] : 1'b0;
        if (loopback)
            receptor_i = m_tx ^ g ^ (m_run && (m_cnt < n_err));
        #1;
        exp_ready = load_i ? 1'b0 : (!m_run ? 1'b1 : (en_i && m_cnt == SF - 1));
        checks++;
        if (data_ready_o !== exp_ready) begin
            failures++;
            $display("FAIL data_ready cyc=%0d got=%b exp=%b", cyc, data_ready_o, exp_ready);
        end
        checks++;
        if (receptor_o !== (receptor_i ^ g)) begin
            failures++;
            $display("FAIL receptor_o cyc=%0d got=%b exp=%b", cyc, receptor_o, receptor_i ^ g);
        end
        if (data_ready_o === 1'b1) ready_hist.push_back(cyc);

        exp_cv  = 1'b0;
        exp_rxv = 1'b0;
        if (load_i) begin
            m_a = eff_seed(seed_i); m_b = eff_seed(seed_i);
            m_cnt = 0; m_ones = 0; m_run = 1'b0;
        end else if (!m_run) begin
            if (data_valid_i) begin
                m_tx = data_i; m_run = 1'b1; void'(src_q.pop_front());
            end
        end else if (en_i) begin
            chip_q.push_back('{cdma: m_tx ^ g, gold: g});
            exp_cv = 1'b1;
            m_ones += int'(receptor_i ^ g);
            m_a = lfsr_next(m_a, TAPS_A);
            m_b = lfsr_next(m_b, TAPS_B);
            if (m_cnt == SF - 1) begin
                m_cnt = 0;
                rx_q.push_back(m_ones > SF / 2);
                exp_rxv = 1'b1;
                m_ones = 0;
                if (data_valid_i) begin
                    m_tx = data_i; void'(src_q.pop_front());
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_cnt++;
            end
        end

        @(posedge clk_i);
        #1;
        checks++;
        if (chip_valid_o !== exp_cv) begin
            failures++;
            $display("FAIL chip_valid cyc=%0d got=%b exp=%b", cyc, chip_valid_o, exp_cv);
        end
        if (exp_cv && chip_q.size() != 0) begin
            c = chip_q.pop_front();
            checks++;
            if ({cdma_o, gold_o} !== {c.cdma, c.gold}) begin
                failures++;
                $display("FAIL chip cyc=%0d got cdma=%b gold=%b exp cdma=%b gold=%b",
                         cyc, cdma_o, gold_o, c.cdma, c.gold);
            end
        end
        if (chip_valid_o === 1'b1) begin
            cv_count++;
            gold_hist.push_back(gold_o);
        end
`ifdef GOLD_CDMA_CORRELATOR_EN
        checks++;
        if (rx_valid_o !== exp_rxv) begin
            failures++;
            $display("FAIL rx_valid cyc=%0d got=%b exp=%b", cyc, rx_valid_o, exp_rxv);
        end
        if (exp_rxv && rx_q.size() != 0) begin
            r = rx_q.pop_front();
            checks++;
            if (rx_bit_o !== r) begin
                failures++;
                $display("FAIL rx_bit cyc=%0d got=%b exp=%b", cyc, rx_bit_o, r);
            end
        end
`else
        checks++;
        if (rx_valid_o !== 1'b0 || rx_bit_o !== 1'b0) begin
            failures++;
            $display("FAIL rx_tied cyc=%0d got valid=%b bit=%b exp 0/0", cyc, rx_valid_o, rx_bit_o);
        end
`endif
        if (rx_valid_o === 1'b1) rx_count++;
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        #1;
        checks++;
        if (led_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_led_zero got=%b exp=0", led_o);
        end
        checks++;
        if ({cdma_o, gold_o, chip_valid_o, rx_bit_o, rx_valid_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {cdma_o, gold_o, chip_valid_o, rx_bit_o, rx_valid_o});
        end
        // Equal LFSRs after reset give a zero Gold chip, so receptor_o passes
        // receptor_i straight through.
        receptor_i = 1'b1;
        #1;
        checks++;
        if (receptor_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_receptor got=%b exp=1", receptor_o);
        end
        receptor_i = 1'b0;
        seed_i = 5'b10110;
        #1;
        checks++;
        if (led_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_led_nonzero got=%b exp=1", led_o);
        end
        do_reset(5'b00000);
    endtask

    task automatic test_period_back_to_back();
        int exp_ready_cyc[3];
        exp_ready_cyc = '{1, 32, 63};
        do_reset(5'b00000);
        en_i = 1'b1;
        src_q = '{1'b0, 1'b0, 1'b0};
        ready_hist.delete();
        gold_hist.delete();
        cv_count = 0;
        cyc = 1;
        run_ticks(63);
        checks++;
        if (ready_hist.size() != 3) begin
            failures++;
            $display("FAIL ready_pulses got=%0d exp=3", ready_hist.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ready_hist[i] != exp_ready_cyc[i]) begin
                    failures++;
                    $display("FAIL ready_cycle[%0d] got=%0d exp=%0d", i, ready_hist[i], exp_ready_cyc[i]);
                end
            end
        end
        // Chips registered on ticks 2..63 must be continuous.
        checks++;
        if (cv_count != 62) begin
            failures++;
            $display("FAIL back_to_back_chips got=%0d exp=62", cv_count);
        end
        run_ticks(33);
        checks++;
        if (gold_hist.size() < 2 * SF) begin
            failures++;
            $display("FAIL gold_period_len got=%0d exp>=%0d", gold_hist.size(), 2 * SF);
        end else begin
            for (int i = 0; i < SF; i++) ref_gold[i] = gold_hist[i];
            for (int i = 0; i < SF; i++) begin
                checks++;
                if (gold_hist[i + SF] !== gold_hist[i]) begin
                    failures++;
                    $display("FAIL gold_period[%0d] got=%b exp=%b", i, gold_hist[i + SF], gold_hist[i]);
                end
            end
        end
    endtask

    task automatic test_loopback();
        do_reset(5'b00001);
        en_i = 1'b1;
        loopback = 1'b1;
        n_err = 0;
        rx_count = 0;
        src_q = '{1'b1, 1'b0, 1'b1};
        run_ticks(3 * SF + 4);
        // Majority threshold: 15 ones decide 0, 16 ones decide 1.
        n_err = 15;
        src_q = '{1'b0};
        run_ticks(SF + 3);
        n_err = 16;
        src_q = '{1'b0};
        run_ticks(SF + 3);
        n_err = 15;
        src_q = '{1'b1};
        run_ticks(SF + 3);
        n_err = 0;
        checks++;
`ifdef GOLD_CDMA_CORRELATOR_EN
        if (rx_count != 6) begin
            failures++;
            $display("FAIL loopback_rx_count got=%0d exp=6", rx_count);
        end
`else
        if (rx_count != 0) begin
            failures++;
            $display("FAIL loopback_rx_count got=%0d exp=0", rx_count);
        end
`endif
        loopback = 1'b0;
    endtask

    task automatic test_en_toggle();
        do_reset(5'b00000);
        loopback = 1'b1;
        en_i = 1'b1;
        src_q = '{1'b0};
        tick();
        gold_hist.delete();
        cv_count = 0;
        for (int i = 0; i < 2 * SF; i++) begin
            en_i = (i % 2 == 0);
            tick();
        end
        en_i = 1'b1;
        checks++;
        if (cv_count != SF) begin
            failures++;
            $display("FAIL en_toggle_pulses got=%0d exp=%0d", cv_count, SF);
        end
        for (int i = 0; i < SF && i < gold_hist.size(); i++) begin
            checks++;
            if (gold_hist[i] !== ref_gold[i]) begin
                failures++;
                $display("FAIL en_toggle_gold[%0d] got=%b exp=%b", i, gold_hist[i], ref_gold[i]);
            end
        end
        run_ticks(3);
        loopback = 1'b0;
    endtask

    task automatic test_load_abort();
        do_reset(5'b00001);
        en_i = 1'b1;
        loopback = 1'b1;
        src_q = '{1'b1};
        run_ticks(11);          // accept + chips 0..9
        src_q = '{1'b0};        // offered during load, must not be taken
        load_i = 1'b1;
        rx_count = 0;
        tick();
        load_i = 1'b0;
        gold_hist.delete();
        run_ticks(20);
        checks++;
        if (rx_count != 0) begin
            failures++;
            $display("FAIL load_no_rx got=%0d exp=0", rx_count);
        end
        // Effective seed 1 in both LFSRs: the first chip after restart is 0.
        checks++;
        if (gold_hist.size() == 0 || gold_hist[0] !== 1'b0) begin
            failures++;
            $display("FAIL load_restart_first_gold got=%b exp=0",
                     (gold_hist.size() != 0) ? gold_hist[0] : 1'bx);
        end
        run_ticks(SF);
        loopback = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset(5'b10110);
        en_i = 1'b1;
        src_q = '{1'b1};
        run_ticks(8);
        #2;
        set_i = 1'b0;
        #1;
        checks++;
        if ({cdma_o, gold_o, chip_valid_o, rx_bit_o, rx_valid_o, data_ready_o} !== 6'b000001) begin
            failures++;
            $display("FAIL async_reset got=%b exp=000001",
                     {cdma_o, gold_o, chip_valid_o, rx_bit_o, rx_valid_o, data_ready_o});
        end
        model_reset();
        src_q.delete();
        set_i = 1'b1;
        @(negedge clk_i);
        src_q = '{1'b0};
        run_ticks(SF + 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_period_back_to_back();
        test_loopback();
        test_en_toggle();
        test_load_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
